// File: rtl/ripple_restoring_divider_pkg.sv
// rtl/ripple_restoring_divider_pkg.sv - shared types and helpers for the restoring divider
// Contents: FSM state encoding (2 bits) and the iteration counter width helper.
package ripple_restoring_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Counter runs WIDTH-1 down to 0, so clog2(WIDTH) bits suffice for WIDTH >= 2.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/ripple_borrow_subtractor.sv
// rtl/ripple_borrow_subtractor.sv - N-bit ripple-borrow subtractor built from 1-bit full subtractors
// Ports:
//   a, b       : N-bit minuend and subtrahend
//   borrow_in  : borrow into bit 0
//   diff       : N-bit difference a - b - borrow_in
//   borrow_out : borrow out of the MSB (set when a < b + borrow_in)
module ripple_borrow_subtractor #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    logic [N:0] borrow;

    assign borrow[0] = borrow_in;

    for (genvar i = 0; i < N; i++) begin : g_fs
        assign diff[i]     = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign borrow_out = borrow[N];

endmodule

// File: rtl/ripple_restoring_divider.sv
// rtl/ripple_restoring_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
// Optional feature macro: RIPPLE_DIV_ZERO_DETECT_EN (divide-by-zero short cut and div_zero flag).
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid, in_ready    : operand handshake
//   dividend, divisor     : WIDTH-bit unsigned operands
//   out_valid, out_ready  : result handshake
//   quotient, remainder   : WIDTH-bit registered results, held until the next result
//   div_zero              : divisor was zero (tied low unless the macro is defined)
module ripple_restoring_divider
    import ripple_restoring_divider_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    // Shift the next dividend bit into the partial remainder and try subtracting.
    assign trial = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    ripple_borrow_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .a          (trial),
        .b          ({1'b0, divisor_reg}),
        .borrow_in  (1'b0),
        .diff       (diff),
        .borrow_out (borrow)
    );

    // Borrow means the divisor did not fit: restore by keeping the trial value.
    assign r_next = borrow ? trial : diff;
    assign q_next = {q_reg[WIDTH-2:0], ~borrow};

    // The partial remainder stays below the divisor, so its MSB is always zero.
    logic unused_r_msb;
    assign unused_r_msb = r_reg[WIDTH];

`ifdef RIPPLE_DIV_ZERO_DETECT_EN
    logic div_zero_reg;
    assign div_zero = div_zero_reg;
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            q_reg        <= '0;
            r_reg        <= '0;
            divisor_reg  <= '0;
            count        <= '0;
`ifdef RIPPLE_DIV_ZERO_DETECT_EN
            div_zero_reg <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        q_reg       <= dividend;
                        divisor_reg <= divisor;
                        r_reg       <= '0;
                        count       <= CW'(WIDTH - 1);
                        in_ready    <= 1'b0;
`ifdef RIPPLE_DIV_ZERO_DETECT_EN
                        if (divisor == '0) begin
                            state        <= ST_DONE;
                            out_valid    <= 1'b1;
                            quotient     <= '1;
                            remainder    <= dividend;
                            div_zero_reg <= 1'b1;
                        end else begin
                            state <= ST_CALC;
                        end
`else
                        state <= ST_CALC;
`endif
                    end
                end

                ST_CALC: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    count <= count - CW'(1);
                    if (count == '0) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
`ifdef RIPPLE_DIV_ZERO_DETECT_EN
                        div_zero_reg <= 1'b0;
`endif
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_restoring_divider.sv
// tb/tb_ripple_restoring_divider.sv - self-checking bench for ripple_restoring_divider
module tb_ripple_restoring_divider;

    localparam int W = 16;
    localparam int N_RAND = 1500;

`ifdef RIPPLE_DIV_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int checks = 0;
    int errors = 0;

    ripple_restoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    vec_t vecs[6];
    exp_t exp_queue[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Behavioural model: plain integer division, all-ones quotient for a zero divisor.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q  = {W{1'b1}};
            e.r  = a;
            e.dz = DZ_EN;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Present operands and return once the acceptance edge has passed.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int waited;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count falling edges after acceptance until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
    endtask

    task automatic run_vec(input vec_t v, input int exp_lat, input logic exp_dz);
        int lat;
        start_op(v.a, v.b);
        wait_result(lat);
        check($sformatf("latency %0d/%0d", v.a, v.b), lat, exp_lat);
        check($sformatf("quotient %0d/%0d", v.a, v.b), quotient, v.q);
        check($sformatf("remainder %0d/%0d", v.a, v.b), remainder, v.r);
        check($sformatf("div_zero %0d/%0d", v.a, v.b), div_zero, exp_dz);
        check("in_ready_in_done", in_ready, 1'b0);
        @(negedge clk);
        check("out_valid_after_accept", out_valid, 1'b0);
        check("in_ready_after_accept", in_ready, 1'b1);
        check("quotient_held_idle", quotient, v.q);
        check("div_zero_cleared", div_zero, 1'b0);
    endtask

    initial begin
        vec_t v;
        int lat;
        int got;
        bit prod_done;

        vecs[0] = '{a: 16'd100,    b: 16'd7,      q: 16'd14,     r: 16'd2};
        vecs[1] = '{a: 16'hFFFF,   b: 16'd1,      q: 16'hFFFF,   r: 16'd0};
        vecs[2] = '{a: 16'hFFFF,   b: 16'hFFFF,   q: 16'd1,      r: 16'd0};
        vecs[3] = '{a: 16'd5,      b: 16'd9,      q: 16'd0,      r: 16'd5};
        vecs[4] = '{a: 16'd60000,  b: 16'd7,      q: 16'd8571,   r: 16'd3};
        vecs[5] = '{a: 16'd1,      b: 16'hFFFF,   q: 16'd0,      r: 16'd1};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset quotient", quotient, 16'd0);
        check("reset remainder", remainder, 16'd0);
        check("reset div_zero", div_zero, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], W + 1, 1'b0);

        // Divide by zero
        v = '{a: 16'd1234, b: 16'd0, q: 16'hFFFF, r: 16'd1234};
        run_vec(v, DZ_EN ? 1 : W + 1, DZ_EN);

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        start_op(16'd1000, 16'd3);
        wait_result(lat);
        check("bp latency", lat, W + 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp out_valid", out_valid, 1'b1);
            check("bp in_ready", in_ready, 1'b0);
            check("bp quotient", quotient, 16'd333);
            check("bp remainder", remainder, 16'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", out_valid, 1'b0);
        check("bp release in_ready", in_ready, 1'b1);
        check("bp release quotient held", quotient, 16'd333);

        // Asynchronous reset in the middle of CALC
        start_op(16'd60000, 16'd7);
        repeat (8) @(negedge clk);
        check("pre-abort out_valid", out_valid, 1'b0);
        reset_n = 1'b0;
        #1;
        check("abort out_valid", out_valid, 1'b0);
        check("abort quotient", quotient, 16'd0);
        check("abort remainder", remainder, 16'd0);
        check("abort in_ready", in_ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        run_vec(vecs[4], W + 1, 1'b0);

        // Random sweep with gaps on both handshakes
        got = 0;
        prod_done = 1'b0;
        fork
            begin
                logic [W-1:0] a, b;
                int sel;
                for (int i = 0; i < N_RAND; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    a = W'($urandom);
                    sel = $urandom_range(0, 63);
                    if (sel == 0)       b = '0;
                    else if (sel < 24)  b = W'($urandom_range(1, 15));
                    else if (sel < 40)  b = W'($urandom_range(1, 255));
                    else                b = W'($urandom);
                    exp_queue.push_back(model(a, b));
                    start_op(a, b);
                end
                prod_done = 1'b1;
            end
            begin
                int cyc;
                exp_t e;
                cyc = 0;
                while (got < N_RAND && cyc < 80000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_queue.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rand_duplicate: result %0h/%0h with none outstanding", quotient, remainder);
                        end else begin
                            e = exp_queue.pop_front();
                            check("rand quotient", quotient, e.q);
                            check("rand remainder", remainder, e.r);
                            check("rand div_zero", div_zero, e.dz);
                        end
                        got++;
                    end
                end
            end
        join
        out_ready = 1'b1;
        check("rand producer done", prod_done, 1'b1);
        check("rand results received", got, N_RAND);
        check("rand nothing outstanding", exp_queue.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
